// File: rtl/program_loader.sv
// Streams a big-endian host byte stream into instruction memory and holds the CPU in reset until a checksum-verified load completes.
// Latency: one im_we pulse the cycle after each word's 4th byte; 5*len_words+2 cycles from start to done with back-to-back bytes.
// Backpressure: byte_ready is high only in RECV and CHECK; gaps in byte_valid simply stall the FSM.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64,
    parameter int          IDX_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [IDX_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_data,
    output logic             im_we,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       sum_q, sum_d;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      im_addr_q, im_addr_d;
    logic [31:0]      im_data_q, im_data_d;
    logic [7:0]       chk_sum;

    assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
    assign im_we      = (state_q == S_WRITE);
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);
    assign cpu_rst    = (state_q != S_DONE);
    assign im_addr    = im_addr_q;
    assign im_data    = im_data_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        sum_d      = sum_q;
        asm_d      = asm_q;
        im_addr_d  = im_addr_q;
        im_data_d  = im_data_q;
        chk_sum    = sum_q + byte_data;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if ((len_words == '0) || (len_words > MAX_LEN)) begin
                        state_d = S_ERROR;
                    end else begin
                        len_d      = len_words;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        sum_d      = '0;
                        state_d    = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (byte_valid) begin
                    asm_d      = {asm_q[15:0], byte_data};
                    sum_d      = chk_sum;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        im_data_d = {asm_q, byte_data};
                        im_addr_d = BASE_ADDR + 32'({word_idx_q, 2'b00});
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                byte_cnt_d = '0;
                state_d    = (word_idx_q == len_q - IDX_W'(1)) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                // The checksum byte makes the 8-bit running sum wrap to zero.
                if (byte_valid) begin
                    state_d = (chk_sum == 8'd0) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            sum_q      <= '0;
            asm_q      <= '0;
            im_addr_q  <= BASE_ADDR;
            im_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            sum_q      <= sum_d;
            asm_q      <= asm_d;
            im_addr_q  <= im_addr_d;
            im_data_q  <= im_data_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader: directed loads with hand-computed writes and status,
// plus hand sequences for reset, mid-load reset and a maximum-length load.
module tb_program_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    program_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .im_we      (im_we),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] len;
        logic [63:0] bytes;
        logic [7:0]  csum;
        logic        hold;
        logic        exp_done;
        logic [7:0]  nw;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [31:0] d1;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl [7];
    wr_t  wq [$];
    int   rdy_cnt;
    int   cyc;
    int   checks;
    int   errors;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (im_we === 1'b1) wq.push_back({im_addr, im_data});
        if (byte_ready === 1'b1) rdy_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge CLK);
        while (!byte_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!byte_ready) begin
            errors++;
            $display("FAIL byte_timeout got ready=%b want 1", byte_ready);
        end
        @(posedge CLK);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic run_entry(input vec_t v);
        int  c0;
        logic bad;
        wq.delete();
        rdy_cnt   = 0;
        start     = 1'b1;
        len_words = v.len;
        c0        = cyc;
        @(posedge CLK);
        #1;
        if (!v.hold) start = 1'b0;
        bad = (v.len == 16'd0) || (v.len > 16'd64);
        if (bad) begin
            chk("lenerr_err", {31'd0, err}, 32'd1);
            chk("lenerr_done", {31'd0, done}, 32'd0);
            chk("lenerr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            byte_valid = 1'b1;
            byte_data  = 8'h55;
            repeat (4) @(posedge CLK);
            #1;
            byte_valid = 1'b0;
            chk("lenerr_ready_cnt", rdy_cnt, 32'd0);
            chk("lenerr_writes", wq.size(), 32'd0);
            chk("lenerr_err_hold", {31'd0, err}, 32'd1);
        end else begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            chk("start_done", {31'd0, done}, 32'd0);
            for (int i = 0; i < 4 * int'(v.len); i++) begin
                send_byte(v.bytes[63 - 8 * i -: 8]);
                if (v.hold) begin
                    @(posedge CLK);
                    #1;
                end
            end
            send_byte(v.csum);
            start = 1'b0;
            if (!v.hold) chk("load_cycles", cyc - c0, 5 * int'(v.len) + 2);
            chk("end_done", {31'd0, done}, {31'd0, v.exp_done});
            chk("end_err", {31'd0, err}, {31'd0, !v.exp_done});
            chk("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !v.exp_done});
            chk("end_busy", {31'd0, busy}, 32'd0);
            chk("end_nwrites", wq.size(), {24'd0, v.nw});
            if (wq.size() > 0) begin
                chk("wr0_addr", wq[0].a, v.a0);
                chk("wr0_data", wq[0].d, v.d0);
            end
            if (wq.size() > 1) begin
                chk("wr1_addr", wq[1].a, v.a1);
                chk("wr1_data", wq[1].d, v.d1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic [31:0] w;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rdy_cnt = 0;

        //            len    bytes                   csum  hold done nw  a0     d0            a1     d1
        tbl[0] = {16'd2,  64'h2001_0005_0022_1020, 8'h88, 1'b0, 1'b1, 8'd2, 32'd0, 32'h20010005, 32'd4, 32'h00221020};
        tbl[1] = {16'd2,  64'h2001_0005_0022_1020, 8'h00, 1'b0, 1'b0, 8'd2, 32'd0, 32'h20010005, 32'd4, 32'h00221020};
        tbl[2] = {16'd0,  64'h0,                   8'h00, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0,        32'd0, 32'd0};
        tbl[3] = {16'd65, 64'h0,                   8'h00, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0,        32'd0, 32'd0};
        tbl[4] = {16'd2,  64'h2001_0005_0022_1020, 8'h88, 1'b1, 1'b1, 8'd2, 32'd0, 32'h20010005, 32'd4, 32'h00221020};
        tbl[5] = {16'd1,  64'hDEAD_BEEF_0000_0000, 8'hC8, 1'b0, 1'b1, 8'd1, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
        tbl[6] = {16'd2,  64'h2001_0005_0022_1020, 8'h87, 1'b0, 1'b0, 8'd2, 32'd0, 32'h20010005, 32'd4, 32'h00221020};

        RST        = 1'b1;
        start      = 1'b0;
        len_words  = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_im_we", {31'd0, im_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_im_addr", im_addr, 32'd0);
        chk("rst_im_data", im_data, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int t = 0; t < 7; t++) run_entry(tbl[t]);

        // Reset after the 3rd byte of word 1, with the 4th byte on offer at the reset edge.
        wq.delete();
        start     = 1'b1;
        len_words = 16'd2;
        @(posedge CLK);
        #1;
        start = 1'b0;
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h22); send_byte(8'h10);
        byte_valid = 1'b1;
        byte_data  = 8'h20;
        RST        = 1'b1;
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        byte_valid = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("midrst_im_we", {31'd0, im_we}, 32'd0);
        chk("midrst_im_data", im_data, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst_nwrites", wq.size(), 32'd1);
        chk("midrst_state_idle", {31'd0, busy | done | err}, 32'd0);
        run_entry(tbl[0]);

        // Maximum-length load: word i = {i, i^A5, 3C, ~i}.
        wq.delete();
        s         = 8'h00;
        start     = 1'b1;
        len_words = 16'd64;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'(i) ^ 8'hA5, 8'h3C, ~8'(i)};
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[8 * k +: 8]);
                s = s + w[8 * k +: 8];
            end
        end
        send_byte(8'h00 - s);
        chk("max_done", {31'd0, done}, 32'd1);
        chk("max_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("max_nwrites", wq.size(), 32'd64);
        for (int i = 0; i < 64 && i < wq.size(); i++) begin
            w = {8'(i), 8'(i) ^ 8'hA5, 8'h3C, ~8'(i)};
            chk("max_addr", wq[i].a, 32'(4 * i));
            chk("max_data", wq[i].d, w);
        end
        // A restart from DONE puts the CPU back into reset on the next edge.
        start     = 1'b1;
        len_words = 16'd1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
